// File: rtl/vdp_pkg.sv
// Shared types and helpers for the vector-dot-product MAC pipeline.
// sat_add works at a fixed wide width so any accumulator up to SAT_W bits can use it.
package vdp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int SAT_W = 128;

  function automatic int prod_w(input int n, input int m, input int p);
    return n + m + $clog2(p);
  endfunction

  // Returns {ovf, result}. Operands are sign-extended to SAT_W by the caller;
  // the low l bits of result are the wrapped or clamped l-bit sum.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int l, input logic sat);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    logic ovf;
    s   = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi  = ((SAT_W+1)'(1) <<< (l - 1)) - (SAT_W+1)'(1);
    lo  = -hi - (SAT_W+1)'(1);
    ovf = (s > hi) || (s < lo);
    if (ovf && sat)
      s = (s > hi) ? hi : lo;
    return {ovf, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/vdp_dot_stage.sv
// Lane-wise signed multiply and adder-tree reduction, registered at the accept edge.
module vdp_dot_stage
  import vdp_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = N,
  parameter int P  = 4,
  parameter int PW = prod_w(N, M, P)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [P*N-1:0]       A,
  input  logic [P*M-1:0]       B,
  output logic signed [PW-1:0] psum_p1,
  output logic                 vld_p1
);

  logic signed [PW-1:0] sum_c;

  // Each product is formed at PW bits so the reduction never truncates.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < P; i++)
      sum_c = sum_c + PW'($signed(A[i*N +: N])) * PW'($signed(B[i*M +: M]));
  end

  // ---- stage 1 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) psum_p1 <= sum_c;
  end

endmodule

// File: rtl/vdp_mac_pipe.sv
// Length-programmed signed dot-product MAC: FSM, beat counter, accumulator and flags;
// the multiply/reduce stage lives in vdp_dot_stage.
module vdp_mac_pipe
  import vdp_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = N,
  parameter int P  = 4,
  parameter int L  = 64,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       len,
  input  logic                sat_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [P*N-1:0]      A,
  input  logic [P*M-1:0]      B,
  output logic signed [L-1:0] Y,
  output logic                out_valid,
  output logic                overflow,
  output logic                busy
);

  localparam int PW = prod_w(N, M, P);

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic                 sat_q;
  logic signed [L-1:0]  acc;
  logic signed [PW-1:0] psum_p1;
  logic                 vld_p1;
  logic                 accept;
  logic                 start_ok;
  logic [SAT_W:0]       sa;
  logic signed [L-1:0]  acc_nxt;

  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state == IDLE) || (state == DONE));

  vdp_dot_stage #(.N(N), .M(M), .P(P), .PW(PW)) u_dot (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .A       (A),
    .B       (B),
    .psum_p1 (psum_p1),
    .vld_p1  (vld_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
      RUN:     if (accept && count == CW'(1)) state_nxt = DRAIN;
      DRAIN:   if (!vld_p1) state_nxt = DONE;
      DONE:    state_nxt = start ? ((len != '0) ? RUN : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN);
    busy      = (state == RUN) || (state == DRAIN);
    out_valid = (state == DONE);
  end

  always_comb begin
    sa      = sat_add(SAT_W'(acc), SAT_W'(psum_p1), L, sat_q);
    acc_nxt = L'(sa);
  end

  // ---- stage 2 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sat_q    <= 1'b0;
    end else if (start_ok) begin
      acc      <= '0;
      count    <= len;
      overflow <= 1'b0;
      sat_q    <= sat_en;
    end else begin
      if (accept) count <= count - CW'(1);
      if (vld_p1) begin
        acc      <= acc_nxt;
        overflow <= overflow | sa[SAT_W];
      end
    end
  end

  assign Y = acc;

endmodule

// File: tb/tb_vdp_mac_pipe.sv
// Randomised and directed bench: two instances (L=64 and L=16) share stimulus and are
// checked against a plain-arithmetic dot-product model.
module tb_vdp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        sat_en;
  logic        in_valid;
  logic [31:0] A, B;
  logic signed [63:0] y64;
  logic signed [15:0] y16;
  logic rdy64, ov64, of64, bz64;
  logic rdy16, ov16, of16, bz16;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  vdp_mac_pipe #(.N(8), .M(8), .P(4), .L(64), .CW(16)) u_dut64 (
    .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(rdy64), .A(A), .B(B), .Y(y64),
    .out_valid(ov64), .overflow(of64), .busy(bz64)
  );

  vdp_mac_pipe #(.N(8), .M(8), .P(4), .L(16), .CW(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(rdy16), .A(A), .B(B), .Y(y16),
    .out_valid(ov16), .overflow(of16), .busy(bz16)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [31:0] a, input logic [31:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
    return s;
  endfunction

  // Dot product of all queued beats accumulated into an l-bit signed register.
  function automatic void model(input int l, input bit sat, output longint y, output bit ovf);
    longint acc = 0;
    longint s, hi, lo;
    ovf = 0;
    foreach (qa[k]) begin
      s = acc + lane_sum(qa[k], qb[k]);
      if (l < 64) begin
        hi = (64'sd1 <<< (l - 1)) - 1;
        lo = -hi - 1;
        if (s > hi || s < lo) begin
          ovf = 1;
          if (sat) s = (s > hi) ? hi : lo;
          else     s = (s <<< (64 - l)) >>> (64 - l);
        end
      end
      acc = s;
    end
    y = acc;
  endfunction

  task automatic fill_const(input int n, input logic [31:0] a, input logic [31:0] b);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin qa.push_back(a); qb.push_back(b); end
  endtask

  task automatic fill_rand(input int n);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin qa.push_back($urandom); qb.push_back($urandom); end
  endtask

  task automatic run_job(input int n, input bit sat, input bit gaps, input bit poke);
    longint e64, e16;
    bit o64, o16;
    int idx, cyc, k;
    model(64, sat, e64, o64);
    model(16, sat, e16, o16);
    @(negedge clk);
    start = 1'b1; len = 16'(n); sat_en = sat;
    @(negedge clk);
    start = 1'b0; len = 16'($urandom); sat_en = 1'($urandom);
    chk("y_cleared", y64, 0);
    if (n > 0) begin
      chk("rdy_run", rdy64, 1);
      idx = 0; cyc = 0;
      while (idx < n && cyc < 200) begin
        if (gaps && (cyc % 2 == 1)) begin
          in_valid = 1'b0; A = $urandom; B = $urandom;
        end else begin
          in_valid = 1'b1; A = qa[idx]; B = qb[idx];
        end
        if (poke && cyc == 1) begin start = 1'b1; len = 16'd1; end
        if (in_valid && rdy64) idx++;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
      in_valid = 1'b0;
      chk("beats_taken", idx, n);
      chk("rdy_drain", rdy64, 0);
      chk("busy_drain", bz64, 1);
    end else begin
      chk("rdy_len0", rdy64, 0);
    end
    k = 0;
    while (!ov64 && k < 10) begin @(negedge clk); k++; end
    chk("latency", k, (n > 0) ? 2 : 0);
    chk("y64", y64, e64);
    chk("ovf64", of64, 64'(o64));
    chk("y16", y16, e16);
    chk("ovf16", of16, 64'(o16));
    chk("ov16_sync", ov16, 1);
    @(negedge clk);
    chk("ov_pulse", ov64, 0);
    chk("y_hold", y64, e64);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; len = '0; sat_en = 1'b0; in_valid = 1'b0; A = '0; B = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_y", y64, 0);
    chk("rst_ov", ov64, 0);
    chk("rst_ovf", of64, 0);
    chk("rst_rdy", rdy64, 0);
    chk("rst_busy", bz64, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", rdy64, 0);

    fill_const(1, 32'h04030201, 32'h08070605);  run_job(1, 0, 0, 0);
    fill_const(3, 32'h80808080, 32'h80808080);  run_job(3, 0, 0, 0);
    fill_const(2, 32'h80808080, 32'h7f7f7f7f);  run_job(2, 0, 0, 0);
    fill_const(4, 32'h01010101, 32'hFE02FF01);  run_job(4, 0, 1, 0);
    fill_const(3, 32'h7f7f7f7f, 32'h7f7f7f7f);  run_job(3, 1, 0, 0);
    fill_const(3, 32'h7f7f7f7f, 32'h7f7f7f7f);  run_job(3, 0, 0, 0);
    fill_const(0, 32'h0, 32'h0);                run_job(0, 0, 0, 0);
    fill_rand(4);                               run_job(4, 0, 0, 1);

    // reset in the middle of a job
    fill_rand(5);
    @(negedge clk);
    start = 1'b1; len = 16'd5; sat_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; A = qa[i]; B = qb[i];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_y64", y64, 0);
    chk("mid_rst_y16", y16, 0);
    chk("mid_rst_busy", bz64, 0);
    chk("mid_rst_rdy", rdy64, 0);
    chk("mid_rst_ov", ov64, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov64 || bz64) seen++;
    end
    chk("post_rst_quiet", seen, 0);
    fill_rand(1); run_job(1, 0, 0, 0);

    for (int j = 0; j < 20; j++) begin
      int n;
      bit s, g;
      n = $urandom_range(0, 7);
      s = 1'($urandom);
      g = 1'($urandom);
      if ($urandom_range(0, 2) == 0) fill_const(n, 32'h7f7f7f7f, 32'h7f7f7f7f);
      else fill_rand(n);
      run_job(n, s, g, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
